// File: rtl/mbus_arbiter.sv
// Two-master round-robin arbiter for the shared 32-bit memory bus.
// Grants are decoded from registered state only; the bus mux follows the granted, requesting master.
module mbus_arbiter #(
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_dout,
  input  logic             m0_wen,
  input  logic             m0_lock,
  output logic             m0_gnt,
  input  logic             m1_req,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_dout,
  input  logic             m1_wen,
  input  logic             m1_lock,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] m_din,
  output logic [WIDTH-1:0] mbus_aout,
  output logic [WIDTH-1:0] mbus_dout,
  output logic             mbus_wen,
  input  logic [WIDTH-1:0] mbus_din,
  output logic [1:0]       owner
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic gnt0_s, gnt1_s;
  logic xfer0_s, xfer1_s;
  logic burst_done_s;

  // Grant decode and transfer qualification; reset low kills grants in the same cycle.
  always_comb begin
    gnt0_s       = (state_q == OWN0) & reset;
    gnt1_s       = (state_q == OWN1) & reset;
    xfer0_s      = gnt0_s & m0_req;
    xfer1_s      = gnt1_s & m1_req;
    burst_done_s = (cnt_q >= CNT_LAST);
    m0_gnt       = gnt0_s;
    m1_gnt       = gnt1_s;
    owner        = {gnt1_s, gnt0_s};
    m_din        = mbus_din;
  end

  // Bus mux: drive the owner's fields only on a transfer cycle, zeros otherwise.
  always_comb begin
    mbus_aout = {WIDTH{1'b0}};
    mbus_dout = {WIDTH{1'b0}};
    mbus_wen  = 1'b0;
    if (xfer0_s) begin
      mbus_aout = m0_addr;
      mbus_dout = m0_dout;
      mbus_wen  = m0_wen & reset;
    end else if (xfer1_s) begin
      mbus_aout = m1_addr;
      mbus_dout = m1_dout;
      mbus_wen  = m1_wen & reset;
    end else begin
      mbus_aout = {WIDTH{1'b0}};
      mbus_dout = {WIDTH{1'b0}};
      mbus_wen  = 1'b0;
    end
  end

  // Next-state: tie goes to the master that was not granted last; preemption needs contention,
  // no lock, and the owner's BURST_MAX-th transfer (or a saturated counter).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
        end else if (m1_req && !m0_lock && burst_done_s) begin
          state_d = OWN1;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
        end else if (m0_req && !m1_lock && burst_done_s) begin
          state_d = OWN0;
        end else begin
          state_d = OWN1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst counter and round-robin pointer bookkeeping.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
      if (state_d == OWN0) begin
        last_d = 1'b0;
      end else if (state_d == OWN1) begin
        last_d = 1'b1;
      end else begin
        last_d = last_q;
      end
    end else if ((xfer0_s || xfer1_s) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset; last=1 lets master 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mbus_arbiter.sv
// Directed scoreboard bench for mbus_arbiter: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_mbus_arbiter;

  localparam logic [31:0] A0 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h0000_1004;
  localparam logic [31:0] D1 = 32'hA5A5_A5A5;
  localparam logic [31:0] Z  = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wen, m0_lock, m0_gnt;
  logic [31:0] m0_addr, m0_dout;
  logic        m1_req, m1_wen, m1_lock, m1_gnt;
  logic [31:0] m1_addr, m1_dout;
  logic [31:0] m_din, mbus_aout, mbus_dout, mbus_din;
  logic        mbus_wen;
  logic [1:0]  owner;

  typedef struct {
    logic        g0;
    logic        g1;
    logic        wen;
    logic [1:0]  own;
    logic [31:0] aout;
    logic [31:0] dout;
    logic [31:0] din;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  mbus_arbiter #(.WIDTH(32), .BURST_MAX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_dout   (m0_dout),
    .m0_wen    (m0_wen),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_dout   (m1_dout),
    .m1_wen    (m1_wen),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m_din     (m_din),
    .mbus_aout (mbus_aout),
    .mbus_dout (mbus_dout),
    .mbus_wen  (mbus_wen),
    .mbus_din  (mbus_din),
    .owner     (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge (inputs change just after the rising edge).
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("m0_gnt",    {31'd0, m0_gnt},   {31'd0, e.g0});
      chk("m1_gnt",    {31'd0, m1_gnt},   {31'd0, e.g1});
      chk("owner",     {30'd0, owner},    {30'd0, e.own});
      chk("mbus_wen",  {31'd0, mbus_wen}, {31'd0, e.wen});
      chk("mbus_aout", mbus_aout,         e.aout);
      chk("mbus_dout", mbus_dout,         e.dout);
      chk("m_din",     m_din,             e.din);
    end
  end

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc(input logic g0, input logic g1, input logic wen,
                     input logic [31:0] aout, input logic [31:0] dout);
    exp_t e;
    e.g0   = g0;
    e.g1   = g1;
    e.own  = {g1, g0};
    e.wen  = wen;
    e.aout = aout;
    e.dout = dout;
    e.din  = mbus_din;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    m0_req = 1'b1; m0_addr = A0; m0_dout = D0; m0_wen = 1'b1; m0_lock = 1'b0;
    m1_req = 1'b1; m1_addr = A1; m1_dout = D1; m1_wen = 1'b1; m1_lock = 1'b0;
    mbus_din = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // Reset held with both masters requesting and writing: nothing granted, nothing written.
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    // First tie after reset goes to master 0; contention: 8 m0 transfers from its grant.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, A0, D0);
    mbus_din = 32'h0BAD_F00D;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, A1, D1);
    cyc(1'b1, 1'b0, 1'b1, A0, D0);

    // Lock: m0 keeps the bus for 20 locked cycles, then hands over on the next edge.
    m0_lock = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, A0, D0);
    m0_lock = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, A0, D0);
    cyc(1'b0, 1'b1, 1'b1, A1, D1);

    // Release with the other master waiting: gnt stays but no transfer, then direct handover.
    m1_req = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, Z, Z);
    cyc(1'b1, 1'b0, 1'b1, A0, D0);
    m0_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, Z, Z);
    cyc(1'b0, 1'b0, 1'b0, Z, Z);

    // Tie from IDLE with last = master 0: master 1 wins.
    m0_req = 1'b1; m1_req = 1'b1; m0_wen = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    cyc(1'b0, 1'b1, 1'b1, A1, D1);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, Z, Z);
    cyc(1'b0, 1'b0, 1'b0, Z, Z);

    // Single uncontested master keeps the bus past BURST_MAX; a late request takes over next edge.
    m1_req = 1'b1;
    mbus_din = 32'h1234_5678;
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, A1, D1);
    m0_req = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, A1, D1);
    cyc(1'b1, 1'b0, 1'b0, A0, D0);
    m0_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, Z, Z);
    cyc(1'b0, 1'b1, 1'b1, A1, D1);

    // Reset mid-burst: write suppressed in the same cycle; afterwards the tie goes to master 0.
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    reset = 1'b1;
    m0_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, Z, Z);
    cyc(1'b1, 1'b0, 1'b0, A0, D0);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, Z, Z);
    cyc(1'b0, 1'b0, 1'b0, Z, Z);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbus_arbiter.md
# mbus_arbiter

Two-master arbiter for the 32-bit memory bus between the CPU and a second bus master (DMA engine or debug port). It selects one owner per cycle and muxes that owner's address, write data and write-enable onto the shared bus toward the address decoder and slaves. Read data is broadcast back to both masters. Arbitration is round-robin, with a bounded burst length and an optional per-master lock.

## Interface
- WIDTH, 32, data and address width of the bus
- BURST_MAX, 8, maximum transfers an owner keeps under contention (range 1..255)
- clk  in  1  system clock
- reset  in  1  reset; synchronous and active-low
- m0_req  in  1  master 0 (CPU) requests the bus; its transfer fields are valid while high
- m0_addr  in  WIDTH  master 0 address
- m0_dout  in  WIDTH  master 0 write data
- m0_wen  in  1  master 0 write enable
- m0_lock  in  1  master 0 forbids preemption while it owns the bus
- m0_gnt  out  1  master 0 owns the bus this cycle
- m1_req, m1_addr, m1_dout, m1_wen, m1_lock, m1_gnt  same as m0_*, for master 1
- m_din  out  WIDTH  read data, broadcast (= mbus_din)
- mbus_aout  out  WIDTH  bus address
- mbus_dout  out  WIDTH  bus write data
- mbus_wen  out  1  bus write enable
- mbus_din  in  WIDTH  read data from the slave mux
- owner  out  2  status: 00 idle, 01 master 0, 10 master 1

## Operation
- State register: IDLE, OWN0, OWN1. Also: round-robin pointer `last` (last granted master), burst counter `cnt` (width clog2(BURST_MAX+1)).
- mN_gnt = (state==OWNN) & reset. gnt is decoded from registered state and never depends combinationally on req.
- Transfer: occurs in any cycle with gnt_N & req_N. On that cycle mbus_aout/mbus_dout = mN_addr/mN_dout and mbus_wen = mN_wen.
- No transfer (IDLE, or owner's req low): mbus_aout=0, mbus_dout=0, mbus_wen=0.
- mbus_wen is additionally ANDed with reset.
- IDLE:
  - one req high → OWN of that master.
  - both high → OWN of the master ≠ `last`.
  - none → stay IDLE.
- OWNx, other master y:
  - req_x low → OWNy if req_y, else IDLE.
  - req_x high, req_y high, lock_x low, and this cycle is x's BURST_MAX-th transfer (cnt==BURST_MAX-1) or later (cnt==BURST_MAX) → OWNy.
  - otherwise stay OWNx.
- cnt:
  - cleared to 0 on every state change.
  - incremented on each transfer cycle; saturates at BURST_MAX.
- `last` is updated to x on entry to OWNx.
- Handover OWNx→OWNy is direct, with no IDLE bubble.
- lock_x high pins ownership regardless of cnt. Dropping req_x still releases ownership even with lock high.

## Timing
- Reset (reset low at a clk edge): state=IDLE, last=1 (master 0 wins the first tie), cnt=0.
- Reset outputs: m0_gnt=m1_gnt=0, owner=00, mbus_wen=0, mbus_aout=mbus_dout=0.
- While reset is low, gnt and mbus_wen are forced 0 combinationally. Reset mid-burst therefore aborts in the same cycle, with no write issued.
- Grant latency from IDLE: req sampled high at edge k → gnt high in cycle k+1, first transfer in cycle k+1.
- Release: owner drops req in cycle k → gnt falls after edge k.
  - If the other master is waiting, its gnt rises in cycle k+1.
  - Cycle k carries no transfer.
- Preemption: owner with continuous req, contested, unlocked, granted starting cycle s → transfers in cycles s..s+BURST_MAX-1, other master granted from cycle s+BURST_MAX.
- Uncontested owner keeps the bus indefinitely. cnt stays at BURST_MAX. A late request from the other master then takes over on the next edge.
- Reads: m_din = mbus_din combinationally. Slave read timing is unchanged by the arbiter. A master uses m_din only in its own granted cycles.
- Simultaneous req rise from both masters in IDLE: tie resolved by `last` only.

## Test plan
- Reset: hold reset=0 with m0_req=m1_req=1, m0_wen=1 → m0_gnt=m1_gnt=0, mbus_wen=0, owner=00. Release reset → cycle after, m0_gnt=1, owner=01.
- Single master: m1_req=1, m1_addr=0x1004, m1_wen=1, m1_dout=0xA5A5A5A5 for 3 cycles → gnt one cycle later. Bus shows 0x1004/0xA5A5A5A5/wen=1 for 3 cycles. After req drops: IDLE, mbus_wen=0.
- Contention, BURST_MAX=8: m0 owns, m1_req rises and both stay high → exactly 8 m0 transfers counted from m0's grant, then m1_gnt. Then 8 m1 transfers and back to m0. No idle cycle between owners.
- Lock: as above with m0_lock=1 for 20 cycles → m0 keeps the bus for all 20. m1_gnt rises the cycle after m0_lock drops (cnt already saturated).
- Round-robin tie: from IDLE with last=0, raise both reqs in the same cycle → m1 granted first.
- Reset mid-burst: m1 writing, reset=0 for one cycle → mbus_wen=0 in that cycle, state IDLE next cycle. After release with both reqs high → m0 wins.
